// File: rtl/cpu_pkg.sv
// Shared constants for the multicycle CPU execute stage: datapath width,
// ALU operation codes and result-source select encodings.
package cpu_pkg;
    localparam int WIDTH = 16;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_NAND = 4'd6;
    localparam logic [3:0] ALU_NOTA = 4'd7;
    localparam logic [3:0] ALU_PASA = 4'd8;
    localparam logic [3:0] ALU_PASB = 4'd9;
    localparam logic [3:0] ALU_SLT  = 4'd10;
    localparam logic [3:0] ALU_SLTU = 4'd11;
    localparam logic [3:0] ALU_SLL  = 4'd12;
    localparam logic [3:0] ALU_SRL  = 4'd13;
    localparam logic [3:0] ALU_SRA  = 4'd14;
    localparam logic [3:0] ALU_ZERO = 4'd15;

    localparam logic RES_SRC_ALU   = 1'b0;
    localparam logic RES_SRC_SHIFT = 1'b1;
endpackage

// File: rtl/alu16_core.sv
// Combinational ALU with zero flag. Arithmetic wraps; shifts use in_b[3:0] only.
module alu16_core #(
    parameter int WIDTH = cpu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] r,
    output logic             isZero
);
    import cpu_pkg::*;

    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic [3:0]              w_sh;

    assign w_a_s = in_a;
    assign w_b_s = in_b;
    assign w_sh  = in_b[3:0];

    always_comb begin
        r = '0;
        case (op)
            ALU_ADD:  r = in_a + in_b;
            ALU_SUB:  r = in_a - in_b;
            ALU_AND:  r = in_a & in_b;
            ALU_OR:   r = in_a | in_b;
            ALU_XOR:  r = in_a ^ in_b;
            ALU_NOR:  r = ~(in_a | in_b);
            ALU_NAND: r = ~(in_a & in_b);
            ALU_NOTA: r = ~in_a;
            ALU_PASA: r = in_a;
            ALU_PASB: r = in_b;
            ALU_SLT:  r[0] = (w_a_s < w_b_s);
            ALU_SLTU: r[0] = (in_a < in_b);
            ALU_SLL:  r = in_a << w_sh;
            ALU_SRL:  r = in_a >> w_sh;
            ALU_SRA:  r = w_a_s >>> w_sh;
            default:  r = '0;
        endcase
    end

    assign isZero = (r == '0);
endmodule

// File: rtl/alu16_res_stage.sv
// Execute-stage slice: ALU and external shifter result selected into the
// write-enabled Res register that drives later stages.
module alu16_res_stage #(
    parameter int WIDTH = cpu_pkg::WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] ALUInA,
    input  logic [WIDTH-1:0] ALUInB,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] ShifterOut,
    input  logic             ResSource,
    input  logic             ResWrite,
    output logic [WIDTH-1:0] ResOut,
    output logic             isZero
);
    import cpu_pkg::*;

    logic [WIDTH-1:0] w_alu_r;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] r_res;

    alu16_core #(.WIDTH(WIDTH)) u_alu (
        .in_a   (ALUInA),
        .in_b   (ALUInB),
        .op     (ALUop),
        .r      (w_alu_r),
        .isZero (isZero)
    );

    assign w_res_next = (ResSource == RES_SRC_SHIFT) ? ShifterOut : w_alu_r;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_res <= '0;
        else if (ResWrite)
            r_res <= w_res_next;
    end

    assign ResOut = r_res;
endmodule

// File: tb/tb_alu16_res_stage.sv
// Directed bench for alu16_res_stage: reset, ALU ops, zero flag, mux, enable, op sweep.
module tb_alu16_res_stage;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] ALUInA;
    logic [15:0] ALUInB;
    logic [3:0]  ALUop;
    logic [15:0] ShifterOut;
    logic        ResSource;
    logic        ResWrite;
    logic [15:0] ResOut;
    logic        isZero;

    int n_tests = 0;
    int n_fail  = 0;

    alu16_res_stage #(.WIDTH(16)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ALUInA     (ALUInA),
        .ALUInB     (ALUInB),
        .ALUop      (ALUop),
        .ShifterOut (ShifterOut),
        .ResSource  (ResSource),
        .ResWrite   (ResWrite),
        .ResOut     (ResOut),
        .isZero     (isZero)
    );

    always #5 CLK = ~CLK;

    // Independent reference: SUB via two's-complement add, SLT via sign rules, SRA via bitwise shifting.
    function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
        logic [15:0] t;
        int sh;
        sh = int'(b[3:0]);
        t = 16'h0000;
        case (op)
            4'd0:  t = a + b;
            4'd1:  t = a + (~b) + 16'd1;
            4'd2:  t = a & b;
            4'd3:  t = a | b;
            4'd4:  t = a ^ b;
            4'd5:  t = ~(a | b);
            4'd6:  t = ~(a & b);
            4'd7:  t = ~a;
            4'd8:  t = a;
            4'd9:  t = b;
            4'd10: t = {15'd0, (a[15] != b[15]) ? a[15] : (a < b)};
            4'd11: t = {15'd0, (a < b)};
            4'd12: t = a << sh;
            4'd13: t = a >> sh;
            4'd14: begin
                t = a;
                for (int k = 0; k < sh; k++) t = {t[15], t[15:1]};
            end
            default: t = 16'h0000;
        endcase
        return t;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; ALUInA = 16'h0; ALUInB = 16'h0; ALUop = 4'd0;
        ShifterOut = 16'h0; ResSource = 1'b0; ResWrite = 1'b0;
        step();
        n_tests++;
        if (ResOut !== 16'h0000) begin
            n_fail++; $display("FAIL reset_init: ResOut=%h expected 0000", ResOut);
        end
        @(negedge CLK);
        RESET = 1'b0;
        ALUInA = 16'hBEEF; ALUop = 4'd8; ResWrite = 1'b1;
        step();
        n_tests++;
        if (ResOut !== 16'hBEEF) begin
            n_fail++; $display("FAIL load_beef: ResOut=%h expected beef", ResOut);
        end
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        n_tests++;
        if (ResOut !== 16'h0000) begin
            n_fail++; $display("FAIL async_reset: ResOut=%h expected 0000", ResOut);
        end
        step();
        n_tests++;
        if (ResOut !== 16'h0000) begin
            n_fail++; $display("FAIL reset_over_write: ResOut=%h expected 0000", ResOut);
        end
        #2 RESET = 1'b0;
        ALUInA = 16'h0042;
        step();
        n_tests++;
        if (ResOut !== 16'h0042) begin
            n_fail++; $display("FAIL post_release_load: ResOut=%h expected 0042", ResOut);
        end
    endtask

    task automatic test_add_sub();
        @(negedge CLK);
        ALUInA = 16'hFFFF; ALUInB = 16'h0001; ALUop = 4'd0;
        ShifterOut = 16'h5A5A; ResSource = 1'b0; ResWrite = 1'b1;
        #1;
        n_tests++;
        if (isZero !== 1'b1) begin
            n_fail++; $display("FAIL add_wrap_zero: isZero=%b expected 1", isZero);
        end
        step();
        n_tests++;
        if (ResOut !== 16'h0000) begin
            n_fail++; $display("FAIL add_wrap_res: ResOut=%h expected 0000", ResOut);
        end
        @(negedge CLK);
        ALUInA = 16'd5; ALUInB = 16'd7; ALUop = 4'd1;
        #1;
        n_tests++;
        if (dut.w_alu_r !== 16'hFFFE || isZero !== 1'b0) begin
            n_fail++; $display("FAIL sub_neg: r=%h z=%b expected fffe 0", dut.w_alu_r, isZero);
        end
        step();
        n_tests++;
        if (ResOut !== 16'hFFFE) begin
            n_fail++; $display("FAIL sub_res: ResOut=%h expected fffe", ResOut);
        end
    endtask

    task automatic test_logic_cmp();
        logic [3:0]  ops [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd10, 4'd11};
        logic [15:0] av  [6] = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h8000, 16'h8000};
        logic [15:0] bv  [6] = '{16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h0001, 16'h0001};
        logic [15:0] ev  [6] = '{16'h00F0, 16'hFFF0, 16'hFF00, 16'h000F, 16'h0001, 16'h0000};
        ResSource = 1'b0; ResWrite = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            ALUInA = av[i]; ALUInB = bv[i]; ALUop = ops[i];
            step();
            n_tests++;
            if (ResOut !== ev[i] || isZero !== (ev[i] == 16'h0)) begin
                n_fail++;
                $display("FAIL logic_cmp op=%0d: ResOut=%h z=%b expected %h %b",
                         ops[i], ResOut, isZero, ev[i], ev[i] == 16'h0);
            end
        end
    endtask

    task automatic test_shifts();
        logic [3:0]  ops [3] = '{4'd12, 4'd13, 4'd14};
        logic [15:0] ev  [3] = '{16'h0010, 16'h0800, 16'hF800};
        ResSource = 1'b0; ResWrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            ALUInA = 16'h8001; ALUInB = 16'h0014; ALUop = ops[i];
            step();
            n_tests++;
            if (ResOut !== ev[i]) begin
                n_fail++;
                $display("FAIL shift op=%0d: ResOut=%h expected %h", ops[i], ResOut, ev[i]);
            end
        end
    endtask

    task automatic test_mux_enable();
        logic [15:0] av [3] = '{16'd1, 16'd3, 16'd5};
        logic [15:0] bv [3] = '{16'd2, 16'd3, 16'd9};
        logic [3:0]  ov [3] = '{4'd0, 4'd1, 4'd15};
        logic        zv [3] = '{1'b0, 1'b1, 1'b1};
        @(negedge CLK);
        ALUInA = 16'h0; ALUInB = 16'h0; ALUop = 4'd0;
        ShifterOut = 16'h1234; ResSource = 1'b1; ResWrite = 1'b1;
        step();
        n_tests++;
        if (ResOut !== 16'h1234 || isZero !== 1'b1) begin
            n_fail++; $display("FAIL mux_shift: ResOut=%h z=%b expected 1234 1", ResOut, isZero);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            ResWrite = 1'b0; ResSource = i[0];
            ALUInA = av[i]; ALUInB = bv[i]; ALUop = ov[i]; ShifterOut = 16'h0000;
            step();
            n_tests++;
            if (ResOut !== 16'h1234 || isZero !== zv[i]) begin
                n_fail++;
                $display("FAIL hold_%0d: ResOut=%h z=%b expected 1234 %b", i, ResOut, isZero, zv[i]);
            end
        end
    endtask

    task automatic test_op_sweep();
        logic [15:0] a, b, e;
        ResSource = 1'b0; ResWrite = 1'b1;
        for (int op = 0; op < 16; op++) begin
            for (int j = 0; j < 5; j++) begin
                @(negedge CLK);
                a = 16'($urandom);
                b = (j == 0) ? a : 16'($urandom);
                ALUInA = a; ALUInB = b; ALUop = 4'(op);
                ShifterOut = 16'($urandom);
                e = ref_alu(a, b, 4'(op));
                #1;
                n_tests++;
                if (isZero !== (e == 16'h0)) begin
                    n_fail++;
                    $display("FAIL sweep_zero op=%0d a=%h b=%h: z=%b expected %b", op, a, b, isZero, e == 16'h0);
                end
                step();
                n_tests++;
                if (ResOut !== e) begin
                    n_fail++;
                    $display("FAIL sweep_res op=%0d a=%h b=%h: ResOut=%h expected %h", op, a, b, ResOut, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic_cmp();
        test_shifts();
        test_mux_enable();
        test_op_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
